// File: rtl/muldiv_if.sv
// Handshake/data bundle between the Execute stage and the mul/div sequencer.
//   Start, Op, OperandA, OperandB : instruction issue (forwarded rs/rt)
//   HiLoRead                      : MFHI/MFLO in EX this cycle
//   Flush                         : squash any in-flight operation
//   Busy, Stall                   : operation in flight / hold the pipeline
//   Done, DivByZero               : result-valid pulse, divide-by-zero pulse
//   HiOut, LoOut                  : architectural HI/LO registers
interface muldiv_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             HiLoRead;
  logic             Flush;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport slave (
    input  Start, Op, OperandA, OperandB, HiLoRead, Flush,
    output Busy, Stall, Done, DivByZero, HiOut, LoOut
  );

  modport master (
    output Start, Op, OperandA, OperandB, HiLoRead, Flush,
    input  Busy, Stall, Done, DivByZero, HiOut, LoOut
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller owning the HI/LO pair.
// Iterative shift-add multiply, restoring divide, MADD/MSUB accumulate, MTHI/MTLO.
//   Clk  : rising-edge clock
//   Rst  : asynchronous active-low reset
//   bus  : muldiv_if slave (issue, flush, stall/busy, done pulses, HI/LO)
// Signed operations run on magnitudes; the sign is restored in the FIXUP cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     Clk,
  input logic     Rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000, OP_MULTU = 3'b001,
                         OP_DIV   = 3'b010, OP_DIVU  = 3'b011,
                         OP_MADD  = 3'b100, OP_MSUB  = 3'b101,
                         OP_MTHI  = 3'b110, OP_MTLO  = 3'b111;

  state_t           state, nextState;
  logic [2:0]       opR;
  logic             signA, signB, divZero;
  logic [WIDTH-1:0] mcand;      // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] pHi, pLo;   // product / {remainder, quotient}
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hiR, loR;
  logic             doneR, dbzR;

  // issue decode
  logic             accept, isSigned, isMul, isDiv, bZero;
  logic [WIDTH-1:0] absA, absB;
  assign accept   = (state == IDLE) & bus.Start & ~bus.Flush;
  assign isSigned = (bus.Op == OP_MULT) | (bus.Op == OP_DIV) |
                    (bus.Op == OP_MADD) | (bus.Op == OP_MSUB);
  assign isMul    = (bus.Op == OP_MULT) | (bus.Op == OP_MULTU) |
                    (bus.Op == OP_MADD) | (bus.Op == OP_MSUB);
  assign isDiv    = (bus.Op == OP_DIV)  | (bus.Op == OP_DIVU);
  assign bZero    = (bus.OperandB == '0);
  assign absA     = (isSigned & bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
  assign absB     = (isSigned & bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;

  // one iteration of each algorithm
  logic [WIDTH:0] mulSum, divShift, divTrial;
  assign mulSum   = {1'b0, pHi} + (pLo[0] ? {1'b0, mcand} : '0);
  assign divShift = {pHi, pLo[WIDTH-1]};
  // remainder < divisor, so the trial difference always fits WIDTH+1 bits signed
  assign divTrial = divShift - {1'b0, mcand};

  // sign restoration and accumulate
  logic                 neg;
  logic [2*WIDTH-1:0]   prodS, accAdd, accSub;
  logic [WIDTH-1:0]     quo, rem;
  assign neg    = signA ^ signB;
  assign prodS  = neg ? -{pHi, pLo} : {pHi, pLo};
  assign accAdd = {hiR, loR} + prodS;
  assign accSub = {hiR, loR} - prodS;
  assign quo    = neg ? -pLo : pLo;
  assign rem    = signA ? -pHi : pHi;   // remainder follows dividend sign

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state <= IDLE;
    else      state <= nextState;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (accept) begin
               if (isMul)      nextState = MUL;
               else if (isDiv) nextState = bZero ? FIXUP : DIV;
             end
      MUL, DIV:
             if (bus.Flush)                      nextState = IDLE;
             else if (cnt == CNT_W'(WIDTH - 1))  nextState = FIXUP;
      FIXUP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      opR <= '0; signA <= 1'b0; signB <= 1'b0; divZero <= 1'b0;
      mcand <= '0; pHi <= '0; pLo <= '0; cnt <= '0;
      hiR <= '0; loR <= '0; doneR <= 1'b0; dbzR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      dbzR  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          opR     <= bus.Op;
          signA   <= isSigned & bus.OperandA[WIDTH-1];
          signB   <= isSigned & bus.OperandB[WIDTH-1];
          divZero <= isDiv & bZero;
          cnt     <= '0;
          pHi     <= '0;
          mcand   <= isDiv ? absB : absA;
          pLo     <= isDiv ? absA : absB;
          if (bus.Op == OP_MTHI) begin hiR <= bus.OperandA; doneR <= 1'b1; end
          if (bus.Op == OP_MTLO) begin loR <= bus.OperandA; doneR <= 1'b1; end
        end
        MUL: if (!bus.Flush) begin
          pHi <= mulSum[WIDTH:1];
          pLo <= {mulSum[0], pLo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: if (!bus.Flush) begin
          if (!divTrial[WIDTH]) begin
            pHi <= divTrial[WIDTH-1:0];
            pLo <= {pLo[WIDTH-2:0], 1'b1};
          end else begin
            pHi <= divShift[WIDTH-1:0];
            pLo <= {pLo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIXUP: if (!bus.Flush) begin
          doneR <= 1'b1;
          dbzR  <= divZero;
          if (!divZero) begin
            case (opR)
              OP_MULT, OP_MULTU: {hiR, loR} <= prodS;
              OP_MADD:           {hiR, loR} <= accAdd;
              OP_MSUB:           {hiR, loR} <= accSub;
              OP_DIV, OP_DIVU:   begin loR <= quo; hiR <= rem; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Stall     = bus.Busy & (bus.Start | bus.HiLoRead);
  assign bus.Done      = doneR;
  assign bus.DivByZero = dbzR;
  assign bus.HiOut     = hiR;
  assign bus.LoOut     = loR;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MADD = 3'd4, MSUB = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
    int           lat;
  } vec_t;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // present Start for cycle 0; returns at the falling edge inside cycle 1
  task automatic startOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  vec_t tbl[21];
  int   cyc;
  logic sawDone;

  initial begin
    tbl[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    tbl[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    tbl[2]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 34};
    tbl[3]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    tbl[4]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    tbl[5]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
    tbl[6]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    tbl[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    tbl[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    tbl[9]  = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    tbl[10] = '{DIVU,  32'd5,        32'd10,       32'h00000005, 32'h00000000, 1'b0, 34};
    tbl[11] = '{MTHI,  32'h1234,     32'd0,        32'h00001234, 32'h00000000, 1'b0, 1};
    tbl[12] = '{MTLO,  32'h1234,     32'd0,        32'h00001234, 32'h00001234, 1'b0, 1};
    tbl[13] = '{DIV,   32'd5,        32'd0,        32'h00001234, 32'h00001234, 1'b1, 2};
    tbl[14] = '{DIVU,  32'd9,        32'd0,        32'h00001234, 32'h00001234, 1'b1, 2};
    tbl[15] = '{MTHI,  32'd0,        32'd0,        32'h00000000, 32'h00001234, 1'b0, 1};
    tbl[16] = '{MTLO,  32'd5,        32'd0,        32'h00000000, 32'h00000005, 1'b0, 1};
    tbl[17] = '{MADD,  32'd2,        32'd3,        32'h00000000, 32'h0000000B, 1'b0, 34};
    tbl[18] = '{MSUB,  32'd4,        32'd4,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 34};
    tbl[19] = '{MADD,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFF5, 1'b0, 34};
    tbl[20] = '{MSUB,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEF, 1'b0, 34};

    bus.Start = 1'b0; bus.Op = '0; bus.OperandA = '0; bus.OperandB = '0;
    bus.HiLoRead = 1'b0; bus.Flush = 1'b0;

    // reset state
    repeat (3) @(negedge Clk);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_dbz",  bus.DivByZero, 0);
    chk("rst_hilo", {bus.HiOut, bus.LoOut}, 64'd0);
    Rst = 1'b1;

    // table-driven vectors
    foreach (tbl[i]) begin
      startOp(tbl[i].op, tbl[i].a, tbl[i].b);
      cyc = 1;
      while (!bus.Done && cyc < 60) begin
        @(negedge Clk);
        cyc++;
      end
      chk($sformatf("v%0d_lat", i), cyc, tbl[i].lat);
      chk($sformatf("v%0d_hi", i),  bus.HiOut, tbl[i].hi);
      chk($sformatf("v%0d_lo", i),  bus.LoOut, tbl[i].lo);
      chk($sformatf("v%0d_dbz", i), bus.DivByZero, tbl[i].dbz);
    end

    // MULT busy/stall profile, ignored Start while busy, Start accepted in Done cycle
    startOp(MULT, 32'hFFFFFFFD, 32'd7);
    for (cyc = 1; cyc <= 34; cyc++) begin
      if (cyc > 1) @(negedge Clk);
      bus.HiLoRead = (cyc >= 5);
      bus.Start    = (cyc == 10) || (cyc == 34);
      bus.Op       = MTLO;
      bus.OperandA = (cyc == 10) ? 32'd99 : 32'd77;
      #1;
      chk($sformatf("p_busy_c%0d", cyc),  bus.Busy,  (cyc <= 33));
      chk($sformatf("p_stall_c%0d", cyc), bus.Stall, (cyc >= 5 && cyc <= 33));
      chk($sformatf("p_done_c%0d", cyc),  bus.Done,  (cyc == 34));
    end
    chk("p_result", {bus.HiOut, bus.LoOut}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge Clk);
    bus.Start = 1'b0; bus.HiLoRead = 1'b0;
    #1;
    chk("p_doneacc_done", bus.Done, 1);
    chk("p_doneacc_lo",   bus.LoOut, 32'd77);
    chk("p_doneacc_hi",   bus.HiOut, 32'hFFFFFFFF);

    // flush mid-MULT
    startOp(MULT, 32'd5, 32'd5);
    sawDone = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge Clk);
      bus.Flush = (cyc == 10);
      #1;
      sawDone |= bus.Done;
      if (cyc == 10) chk("fl_busy_c10", bus.Busy, 1);
      if (cyc == 11) chk("fl_busy_c11", bus.Busy, 0);
    end
    bus.Flush = 1'b0;
    chk("fl_nodone", sawDone, 0);
    chk("fl_hilo", {bus.HiOut, bus.LoOut}, {32'hFFFFFFFF, 32'd77});

    // Flush and Start together in IDLE: nothing happens
    @(negedge Clk);
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = MTHI; bus.OperandA = 32'd55;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    #1;
    chk("sf_done", bus.Done, 0);
    chk("sf_busy", bus.Busy, 0);
    @(negedge Clk);
    chk("sf_hi", bus.HiOut, 32'hFFFFFFFF);

    // asynchronous reset mid-DIV
    startOp(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge Clk);
    chk("rd_busy_before", bus.Busy, 1);
    Rst = 1'b0;
    #1;
    chk("rd_hilo", {bus.HiOut, bus.LoOut}, 64'd0);
    chk("rd_busy", bus.Busy, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // recovery after reset
    startOp(DIVU, 32'd100, 32'd7);
    cyc = 1;
    while (!bus.Done && cyc < 60) begin
      @(negedge Clk);
      cyc++;
    end
    chk("rec_lat", cyc, 34);
    chk("rec_hilo", {bus.HiOut, bus.LoOut}, {32'd2, 32'd14});
    @(negedge Clk);
    chk("rec_done_pulse", bus.Done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
